// File: rtl/io_input_conditioner.sv
// ---------------------------------------------------------------------------
// io_input_conditioner
// Board-side input conditioning for switches and push-buttons feeding the core.
//   * 2-FF synchronisers on every raw pin.
//   * Per-bit debounce for buttons (one counter each), presented active-high.
//   * Whole-vector debounce for switches (one shared counter, the vector must
//     be motionless before a new value is accepted).
//   * Press events: registered one-cycle pulse plus sticky flag with
//     write-1-to-clear; a set on the same edge as a clear wins.
// ---------------------------------------------------------------------------
module io_input_conditioner #(
    parameter int unsigned SW_W        = 32,
    parameter int unsigned BTN_W       = 4,
    parameter int unsigned DEBOUNCE_N  = 50000,
    parameter bit          BTN_ACT_LOW = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [SW_W-1:0]  i_sw_raw,
    input  logic [BTN_W-1:0] i_btn_raw,
    input  logic [BTN_W-1:0] i_evt_clr,
    output logic [SW_W-1:0]  o_io_sw,
    output logic [BTN_W-1:0] o_io_btn,
    output logic [BTN_W-1:0] o_btn_pulse,
    output logic [BTN_W-1:0] o_btn_press,
    output logic             o_sw_changed
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_N);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Raw level of a released button; synchronisers start here so that
    // leaving reset never looks like a press.
    localparam logic [BTN_W-1:0] BTN_REL = {BTN_W{BTN_ACT_LOW}};

    // -----------------------------------------------------------------------
    // Synchronisers
    // -----------------------------------------------------------------------
    logic [BTN_W-1:0] btn_ff1_q, btn_ff2_q;
    logic [SW_W-1:0]  sw_ff1_q, sw_ff2_q, sw_ff3_q;
    logic [BTN_W-1:0] btn_sync;

    // Two-stage capture of the raw pins, plus a third switch stage that keeps
    // the previous synchronised switch vector for motion detection.
    // NOTE: clocked state always uses non-blocking assignments so every
    // register samples the pre-edge value of its neighbours.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            btn_ff1_q <= BTN_REL;
            btn_ff2_q <= BTN_REL;
            sw_ff1_q  <= '0;
            sw_ff2_q  <= '0;
            sw_ff3_q  <= '0;
        end else begin
            btn_ff1_q <= i_btn_raw;
            btn_ff2_q <= btn_ff1_q;
            sw_ff1_q  <= i_sw_raw;
            sw_ff2_q  <= sw_ff1_q;
            sw_ff3_q  <= sw_ff2_q;
        end
    end

    // Active-high view of the synchronised buttons (1 = pressed).
    assign btn_sync = btn_ff2_q ^ BTN_REL;

    // -----------------------------------------------------------------------
    // Button debounce, one independent counter per bit
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] btn_cnt_q [BTN_W];
    logic [CNT_W-1:0] btn_cnt_d [BTN_W];
    logic [BTN_W-1:0] btn_stable_q, btn_stable_d;
    logic [BTN_W-1:0] btn_rise;

    // Per-bit next state: count while the input disagrees with the held
    // level, accept on the last count, restart whenever it agrees again.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        btn_stable_d = btn_stable_q;
        btn_rise     = '0;
        for (int i = 0; i < BTN_W; i++) begin
            btn_cnt_d[i] = '0;
            if (btn_sync[i] != btn_stable_q[i]) begin
                if (btn_cnt_q[i] == CNT_MAX) begin
                    btn_stable_d[i] = btn_sync[i];
                    // Accepting a 1 is by construction a 0 -> 1 transition.
                    btn_rise[i]     = btn_sync[i];
                end else begin
                    btn_cnt_d[i] = btn_cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Button debounce state registers.
    // NOTE: the counter array is a handful of flops, not a RAM, so it is
    // cleared on reset like any other state; a count in progress is discarded.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            btn_stable_q <= '0;
            for (int i = 0; i < BTN_W; i++) begin
                btn_cnt_q[i] <= '0;
            end
        end else begin
            btn_stable_q <= btn_stable_d;
            for (int i = 0; i < BTN_W; i++) begin
                btn_cnt_q[i] <= btn_cnt_d[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Press events
    // -----------------------------------------------------------------------
    logic [BTN_W-1:0] btn_pulse_q, btn_pulse_d;
    logic [BTN_W-1:0] btn_press_q, btn_press_d;

    // Pulse marks the edge on which the debounced level rises; the sticky
    // flag sets on that same edge and a simultaneous clear loses.
    always_comb begin
        btn_pulse_d = btn_rise;
        btn_press_d = btn_rise | (btn_press_q & ~i_evt_clr);
    end

    // Press event registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            btn_pulse_q <= '0;
            btn_press_q <= '0;
        end else begin
            btn_pulse_q <= btn_pulse_d;
            btn_press_q <= btn_press_d;
        end
    end

    // -----------------------------------------------------------------------
    // Switch debounce, one counter for the whole vector
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;
    logic [SW_W-1:0]  sw_stable_q, sw_stable_d;
    logic             sw_chg_q, sw_chg_d;
    logic             sw_moving;
    logic             sw_differs;

    assign sw_moving  = (sw_ff2_q != sw_ff3_q);
    assign sw_differs = (sw_ff2_q != sw_stable_q);

    // Any movement restarts the count; a motionless vector that differs from
    // the held one is accepted once it has stayed put long enough.
    always_comb begin
        sw_cnt_d    = '0;
        sw_stable_d = sw_stable_q;
        sw_chg_d    = 1'b0;
        if (!sw_moving && sw_differs) begin
            if (sw_cnt_q == CNT_MAX) begin
                sw_stable_d = sw_ff2_q;
                sw_chg_d    = 1'b1;
            end else begin
                sw_cnt_d = sw_cnt_q + CNT_ONE;
            end
        end
    end

    // Switch debounce state registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sw_cnt_q    <= '0;
            sw_stable_q <= '0;
            sw_chg_q    <= 1'b0;
        end else begin
            sw_cnt_q    <= sw_cnt_d;
            sw_stable_q <= sw_stable_d;
            sw_chg_q    <= sw_chg_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign o_io_sw      = sw_stable_q;
    assign o_io_btn     = btn_stable_q;
    assign o_btn_pulse  = btn_pulse_q;
    assign o_btn_press  = btn_press_q;
    assign o_sw_changed = sw_chg_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_io_input_conditioner
// Directed scenarios followed by a randomized phase. Expected outputs come
// from a window-based reference model: a level is accepted once the
// synchronised input has shown it for a full window of samples.
// ---------------------------------------------------------------------------
module tb_io_input_conditioner;

    localparam int SW_W  = 32;
    localparam int BTN_W = 4;
    localparam int N     = 4;
    localparam logic [BTN_W-1:0] BTN_REL = '1;

    logic             clk = 1'b0;
    logic             rst;
    logic [SW_W-1:0]  sw_raw;
    logic [BTN_W-1:0] btn_raw;
    logic [BTN_W-1:0] evt_clr;
    logic [SW_W-1:0]  o_io_sw;
    logic [BTN_W-1:0] o_io_btn;
    logic [BTN_W-1:0] o_btn_pulse;
    logic [BTN_W-1:0] o_btn_press;
    logic             o_sw_changed;

    int checks = 0;
    int errors = 0;

    io_input_conditioner #(
        .SW_W        (SW_W),
        .BTN_W       (BTN_W),
        .DEBOUNCE_N  (N),
        .BTN_ACT_LOW (1'b1)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_sw_raw     (sw_raw),
        .i_btn_raw    (btn_raw),
        .i_evt_clr    (evt_clr),
        .o_io_sw      (o_io_sw),
        .o_io_btn     (o_io_btn),
        .o_btn_pulse  (o_btn_pulse),
        .o_btn_press  (o_btn_press),
        .o_sw_changed (o_sw_changed)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [BTN_W-1:0] m_btn_pipe [$];   // raw samples still in flight
    logic [SW_W-1:0]  m_sw_pipe  [$];
    logic [BTN_W-1:0] m_btn_hist [$];   // last N synchronised button samples
    logic [SW_W-1:0]  m_sw_hist  [$];   // last N+1 synchronised switch samples
    logic [BTN_W-1:0] exp_btn, exp_pulse, exp_press;
    logic [SW_W-1:0]  exp_sw;
    logic             exp_chg;

    task automatic model_reset();
        exp_btn   = '0;
        exp_pulse = '0;
        exp_press = '0;
        exp_sw    = '0;
        exp_chg   = 1'b0;
        m_btn_pipe.delete();
        m_sw_pipe.delete();
        m_btn_hist.delete();
        m_sw_hist.delete();
        repeat (2) begin
            m_btn_pipe.push_back(BTN_REL);
            m_sw_pipe.push_back('0);
        end
    endtask

    // Called once per rising edge (not in reset) with the inputs as sampled.
    task automatic model_step();
        logic [BTN_W-1:0] sb, rise;
        logic [SW_W-1:0]  ss, last;
        bit               all;
        sb = m_btn_pipe.pop_front();
        m_btn_pipe.push_back(btn_raw);
        ss = m_sw_pipe.pop_front();
        m_sw_pipe.push_back(sw_raw);

        // Buttons: a new level is taken when the last N samples all show it.
        m_btn_hist.push_back(~sb);
        if (m_btn_hist.size() > N) m_btn_hist.delete(0);
        rise = '0;
        if (m_btn_hist.size() == N) begin
            for (int i = 0; i < BTN_W; i++) begin
                all = 1'b1;
                for (int j = 0; j < N; j++)
                    if (m_btn_hist[j][i] == exp_btn[i]) all = 1'b0;
                if (all) begin
                    exp_btn[i] = ~exp_btn[i];
                    rise[i]    = exp_btn[i];
                end
            end
        end
        exp_pulse = rise;
        exp_press = rise | (exp_press & ~evt_clr);

        // Switches: N+1 identical consecutive samples differing from the held value.
        m_sw_hist.push_back(ss);
        if (m_sw_hist.size() > N + 1) m_sw_hist.delete(0);
        exp_chg = 1'b0;
        if (m_sw_hist.size() == N + 1) begin
            last = m_sw_hist[N];
            all  = (last != exp_sw);
            for (int j = 0; j < N + 1; j++)
                if (m_sw_hist[j] != last) all = 1'b0;
            if (all) begin
                exp_sw  = last;
                exp_chg = 1'b1;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("model_io_btn",     64'(o_io_btn),     64'(exp_btn));
        chk("model_btn_pulse",  64'(o_btn_pulse),  64'(exp_pulse));
        chk("model_btn_press",  64'(o_btn_press),  64'(exp_press));
        chk("model_io_sw",      64'(o_io_sw),      64'(exp_sw));
        chk("model_sw_changed", 64'(o_sw_changed), 64'(exp_chg));
    endtask

    // One clock: update the model at the rising edge, compare at the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        compare_all();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int b;

        // 1. Reset with buttons released, then idle
        rst     = 1'b1;
        btn_raw = 4'hF;
        sw_raw  = '0;
        evt_clr = '0;
        model_reset();
        repeat (3) cycle();
        chk("reset_io_btn", 64'(o_io_btn), 64'h0);
        chk("reset_press",  64'(o_btn_press), 64'h0);
        chk("reset_io_sw",  64'(o_io_sw), 64'h0);
        rst = 1'b0;
        repeat (50) begin
            cycle();
            chk("idle_all_zero",
                64'({o_io_btn, o_btn_pulse, o_btn_press, o_sw_changed, o_io_sw}), 64'h0);
        end

        // 2. Press btn0 and hold: accepted after edge k+5
        btn_raw = 4'hE;
        repeat (5) cycle();
        chk("press0_before_latency", 64'(o_io_btn), 64'h0);
        cycle();
        chk("press0_io_btn", 64'(o_io_btn),    64'h1);
        chk("press0_pulse",  64'(o_btn_pulse), 64'h1);
        chk("press0_flag",   64'(o_btn_press), 64'h1);
        cycle();
        chk("press0_pulse_gone", 64'(o_btn_pulse), 64'h0);
        chk("press0_flag_held",  64'(o_btn_press), 64'h1);

        // 3. Short glitch on btn1 (3 cycles) is rejected
        btn_raw = 4'hC;
        repeat (3) cycle();
        btn_raw = 4'hE;
        repeat (12) begin
            cycle();
            chk("glitch1_io_btn", 64'(o_io_btn[1]),    64'h0);
            chk("glitch1_pulse",  64'(o_btn_pulse[1]), 64'h0);
            chk("glitch1_flag",   64'(o_btn_press[1]), 64'h0);
        end

        // 4. Set and clear on the same edge: set wins; later clear alone clears
        btn_raw = 4'hA;
        repeat (6) cycle();
        chk("press2_flag", 64'(o_btn_press[2]), 64'h1);
        btn_raw = 4'hE;
        repeat (8) cycle();
        chk("release2_io_btn", 64'(o_io_btn[2]), 64'h0);
        chk("release2_flag_held", 64'(o_btn_press[2]), 64'h1);
        btn_raw = 4'hA;
        repeat (5) cycle();
        evt_clr = 4'h4;
        cycle();
        evt_clr = 4'h0;
        chk("setclr_pulse", 64'(o_btn_pulse[2]), 64'h1);
        chk("setclr_flag_stays", 64'(o_btn_press[2]), 64'h1);
        cycle();
        chk("setclr_flag_after", 64'(o_btn_press[2]), 64'h1);
        evt_clr = 4'h4;
        cycle();
        evt_clr = 4'h0;
        chk("clr2_alone", 64'(o_btn_press), 64'h1);
        evt_clr = 4'h2;
        cycle();
        evt_clr = 4'h0;
        chk("clr_on_zero_flag", 64'(o_btn_press), 64'h1);

        // 5. Switch vector toggling is held off; settles 6 edges after last change
        sw_raw = 32'hA5;
        for (int t = 0; t < 4; t++) begin
            repeat (2) begin
                cycle();
                chk("sw_toggling_held", 64'(o_io_sw), 64'h0);
            end
            sw_raw = sw_raw ^ 32'h1;
        end
        repeat (6) begin
            cycle();
            chk("sw_settling", 64'({o_sw_changed, o_io_sw}), 64'h0);
        end
        cycle();
        chk("sw_accepted", 64'(o_io_sw), 64'hA5);
        chk("sw_changed_pulse", 64'(o_sw_changed), 64'h1);
        cycle();
        chk("sw_changed_once", 64'(o_sw_changed), 64'h0);

        // 6. Reset in the middle of a debounce
        btn_raw = 4'h2;
        repeat (3) cycle();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("midrst_all_zero",
            64'({o_io_btn, o_btn_pulse, o_btn_press, o_sw_changed, o_io_sw}), 64'h0);
        repeat (2) cycle();
        rst = 1'b0;
        repeat (5) cycle();
        chk("postrst_btn_waiting", 64'(o_io_btn), 64'h0);
        cycle();
        chk("postrst_btn_accepted", 64'(o_io_btn),    64'hD);
        chk("postrst_btn_pulse",    64'(o_btn_pulse), 64'hD);
        chk("postrst_sw_waiting",   64'(o_io_sw),     64'h0);
        cycle();
        chk("postrst_sw_accepted", 64'(o_io_sw), 64'hA5);
        chk("postrst_sw_changed",  64'(o_sw_changed), 64'h1);

        // 7. Randomized traffic against the model
        for (int it = 0; it < 1500; it++) begin
            if ($urandom_range(0, 5) == 0) begin
                b = $urandom_range(0, BTN_W - 1);
                btn_raw[b] = ~btn_raw[b];
            end
            if ($urandom_range(0, 7) == 0) begin
                b = $urandom_range(0, SW_W - 1);
                sw_raw[b] = ~sw_raw[b];
            end
            evt_clr = ($urandom_range(0, 3) == 0) ? BTN_W'($urandom) : '0;
            if (it == 700) begin
                #2;
                rst = 1'b1;
                model_reset();
                #1;
                chk("rand_rst_all_zero",
                    64'({o_io_btn, o_btn_pulse, o_btn_press, o_sw_changed, o_io_sw}), 64'h0);
                cycle();
                rst = 1'b0;
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
